// File: rtl/mor1kx_store_drain.sv
// Store-buffer drain: pops one buffered store at a time, issues it as a data-bus
// write and resolves ack / error / timeout, including store-conditional outcomes.
module mor1kx_store_drain #(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned TIMEOUT_WIDTH        = 8,
    parameter int unsigned ENABLE_TIMEOUT       = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sb_empty_i,
    output logic                              sb_read_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
    input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
    input  logic                              sb_atomic_i,
    input  logic                              atomic_flag_i,
    output logic                              dbus_req_o,
    output logic                              dbus_we_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_dat_o,
    output logic [OPTION_OPERAND_WIDTH/8-1:0] dbus_bsel_o,
    input  logic                              dbus_ack_i,
    input  logic                              dbus_err_i,
    output logic                              atomic_done_o,
    output logic                              atomic_success_o,
    output logic                              store_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   store_err_pc_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   store_err_adr_o,
    input  logic                              err_ack_i,
    output logic                              idle_o
);

    localparam int unsigned DW = OPTION_OPERAND_WIDTH;
    localparam int unsigned BW = OPTION_OPERAND_WIDTH / 8;
    localparam int unsigned CW = TIMEOUT_WIDTH;
    localparam logic        TO_EN = 1'(ENABLE_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_BUS   = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [BW-1:0]   bsel_q, bsel_d;
    logic [DW-1:0]   pc_q, pc_d;
    logic            atomic_q, atomic_d;
    logic            req_q, req_d;
    logic            atomic_done_q, atomic_done_d;
    logic            atomic_success_q, atomic_success_d;
    logic            store_err_q, store_err_d;
    logic [DW-1:0]   err_pc_q, err_pc_d;
    logic [DW-1:0]   err_adr_q, err_adr_d;
    logic            sb_read_c;
    logic            timeout_c;

    // Next-state, entry capture and response resolution
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        adr_d            = adr_q;
        dat_d            = dat_q;
        bsel_d           = bsel_q;
        pc_d             = pc_q;
        atomic_d         = atomic_q;
        req_d            = 1'b0;
        atomic_done_d    = 1'b0;
        atomic_success_d = 1'b0;
        store_err_d      = 1'b0;
        err_pc_d         = err_pc_q;
        err_adr_d        = err_adr_q;
        sb_read_c        = 1'b0;
        timeout_c        = TO_EN & (&cnt_q);

        case (state_q)
            ST_IDLE: begin
                if (!sb_empty_i) begin
                    sb_read_c = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                adr_d    = sb_adr_i;
                dat_d    = sb_dat_i;
                bsel_d   = sb_bsel_i;
                pc_d     = sb_pc_i;
                atomic_d = sb_atomic_i;
                if (sb_atomic_i && !atomic_flag_i) begin
                    atomic_done_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // err outranks ack, ack outranks timeout
                if (dbus_err_i || (!dbus_ack_i && timeout_c)) begin
                    store_err_d   = 1'b1;
                    err_pc_d      = pc_q;
                    err_adr_d     = adr_q;
                    atomic_done_d = atomic_q;
                    state_d       = ST_ERR;
                end else if (dbus_ack_i) begin
                    atomic_done_d    = atomic_q;
                    atomic_success_d = atomic_q;
                    if (!sb_empty_i) begin
                        sb_read_c = 1'b1;
                        state_d   = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    req_d = 1'b1;
                end
            end
            ST_ERR: begin
                if (err_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            adr_q            <= '0;
            dat_q            <= '0;
            bsel_q           <= '0;
            pc_q             <= '0;
            atomic_q         <= 1'b0;
            req_q            <= 1'b0;
            atomic_done_q    <= 1'b0;
            atomic_success_q <= 1'b0;
            store_err_q      <= 1'b0;
            err_pc_q         <= '0;
            err_adr_q        <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            adr_q            <= adr_d;
            dat_q            <= dat_d;
            bsel_q           <= bsel_d;
            pc_q             <= pc_d;
            atomic_q         <= atomic_d;
            req_q            <= req_d;
            atomic_done_q    <= atomic_done_d;
            atomic_success_q <= atomic_success_d;
            store_err_q      <= store_err_d;
            err_pc_q         <= err_pc_d;
            err_adr_q        <= err_adr_d;
        end
    end

    // The store buffer shares rst, so popping while in reset is harmless
    assign sb_read_o        = rst ? !sb_empty_i : sb_read_c;
    assign idle_o           = (state_q == ST_IDLE) && sb_empty_i;
    assign dbus_req_o       = req_q;
    assign dbus_we_o        = req_q;
    assign dbus_adr_o       = adr_q;
    assign dbus_dat_o       = dat_q;
    assign dbus_bsel_o      = bsel_q;
    assign atomic_done_o    = atomic_done_q;
    assign atomic_success_o = atomic_success_q;
    assign store_err_o      = store_err_q;
    assign store_err_pc_o   = err_pc_q;
    assign store_err_adr_o  = err_adr_q;

endmodule

// File: doc/mor1kx_store_drain.md
# mor1kx_store_drain

Drains the store buffer FIFO into the data bus: pops one entry at a time, presents it as a bus write, and waits for acknowledge, error or timeout. It sits directly downstream of the store buffer and upstream of the dbus bridge. It resolves atomic (store-conditional) entries against the reservation flag and reports bus errors with the faulting store's PC and address. `idle_o` is the sync/flush condition for the LSU.

## Interface
- `OPTION_OPERAND_WIDTH`, default 32: address and data width.
- `TIMEOUT_WIDTH`, default 8: bus timeout counter width. Timeout fires after 2^TIMEOUT_WIDTH request cycles without a response.
- `ENABLE_TIMEOUT`, default 1: 0 removes the timeout, so the block waits forever.
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `sb_empty_i`, in, 1: store buffer empty.
- `sb_read_o`, out, 1: pop strobe to the store buffer.
- `sb_adr_i`, in, OPTION_OPERAND_WIDTH: entry address. Valid the cycle after `sb_read_o`.
- `sb_dat_i`, in, OPTION_OPERAND_WIDTH: entry data. Same timing as `sb_adr_i`.
- `sb_bsel_i`, in, OPTION_OPERAND_WIDTH/8: entry byte selects. Same timing.
- `sb_pc_i`, in, OPTION_OPERAND_WIDTH: entry PC. Same timing.
- `sb_atomic_i`, in, 1: entry is a store-conditional. Same timing.
- `atomic_flag_i`, in, 1: reservation currently held.
- `dbus_req_o`, out, 1: bus write request.
- `dbus_we_o`, out, 1: equals `dbus_req_o`.
- `dbus_adr_o`, out, OPTION_OPERAND_WIDTH: bus address.
- `dbus_dat_o`, out, OPTION_OPERAND_WIDTH: bus write data.
- `dbus_bsel_o`, out, OPTION_OPERAND_WIDTH/8: bus byte selects.
- `dbus_ack_i`, in, 1: bus acknowledge.
- `dbus_err_i`, in, 1: bus error.
- `atomic_done_o`, out, 1: one-cycle pulse when an atomic entry resolves.
- `atomic_success_o`, out, 1: valid with `atomic_done_o`.
- `store_err_o`, out, 1: one-cycle pulse on bus error or timeout.
- `store_err_pc_o`, out, OPTION_OPERAND_WIDTH: PC of the faulting store. Held until the next error.
- `store_err_adr_o`, out, OPTION_OPERAND_WIDTH: address of the faulting store. Held until the next error.
- `err_ack_i`, in, 1: releases the ERR state.
- `idle_o`, out, 1: state is IDLE and `sb_empty_i` is high.

## Operation
- FSM states: IDLE, FETCH, BUS, ERR. Reset state is IDLE.
- IDLE:
  - `sb_read_o` = !`sb_empty_i` (combinational).
  - If the buffer is non-empty, go to FETCH.
- FETCH:
  - Capture `sb_*` into the entry registers.
  - If `sb_atomic_i` is high and `atomic_flag_i` is low: no bus cycle; pulse `atomic_done_o` with `atomic_success_o`=0; go to IDLE.
  - Otherwise clear the timeout counter and go to BUS.
- BUS:
  - `dbus_req_o`=`dbus_we_o`=1. `dbus_adr_o`, `dbus_dat_o` and `dbus_bsel_o` come from the entry registers and are stable for the whole request.
  - Error priority: err > ack > timeout.
  - `dbus_err_i` high: pulse `store_err_o`; load `store_err_pc_o`/`store_err_adr_o`; if the entry is atomic, pulse `atomic_done_o` with success 0; go to ERR.
  - `dbus_ack_i` high: if the entry is atomic, pulse `atomic_done_o` with success 1. Then:
    - if `sb_empty_i` is low, assert `sb_read_o` this cycle and go to FETCH (back-to-back);
    - else go to IDLE.
  - Neither, with counter all-ones and ENABLE_TIMEOUT=1: handle exactly as `dbus_err_i`.
  - Neither, otherwise: counter +1.
- ERR:
  - `dbus_req_o`=0 and `sb_read_o`=0; the buffer is not drained.
  - `err_ack_i` returns to IDLE on the next edge.
- `atomic_flag_i` is sampled only in FETCH. Reservation loss during BUS does not cancel an issued write.
- `rst` in any state: next edge goes to IDLE and clears the counter and entry registers. An in-flight request drops without waiting for ack; a late ack arriving in IDLE is ignored. The store buffer shares `rst`.

## Timing
- Reset values:
  - `sb_read_o` is combinational: 1 during reset if `sb_empty_i`=0.
  - `dbus_req_o`, `dbus_we_o`, `atomic_done_o`, `atomic_success_o`, `store_err_o` = 0.
  - `dbus_adr_o`, `dbus_dat_o`, `dbus_bsel_o`, `store_err_pc_o`, `store_err_adr_o` = 0.
  - `idle_o` = `sb_empty_i`.
- Latency: `sb_empty_i` falls in cycle 0 → `sb_read_o` in cycle 0 → FETCH in cycle 1 → `dbus_req_o` in cycle 2.
- Back-to-back: ack in cycle n → `sb_read_o` in cycle n → req again in cycle n+2, so one bubble per store.
- `sb_read_o` is never asserted while `sb_empty_i`=1 or outside IDLE/BUS-ack.
- `atomic_done_o` and `store_err_o` are registered pulses, asserted in the cycle after the resolving edge.
- `idle_o` is combinational.

## Test plan
- Single store (adr 0x100, dat 0xDEADBEEF, bsel 0xF), ack after 3 request cycles → one `sb_read_o` pulse; `dbus_req_o` high for exactly 3 cycles with stable fields; then `idle_o`=1.
- Three queued stores, ack on the first req cycle of each → 3 `sb_read_o` pulses; req pattern is 1,0,1,0,1; bus order matches FIFO order.
- Atomic entry with `atomic_flag_i`=0 → no `dbus_req_o`; `atomic_done_o`=1, `atomic_success_o`=0. Repeat with flag=1 and ack → success=1.
- `dbus_err_i` on entry pc 0x2000, adr 0x300 → `store_err_o` pulse with `store_err_pc_o`=0x2000 and `store_err_adr_o`=0x300; buffer not drained while `err_ack_i`=0; draining resumes after `err_ack_i`.
- TIMEOUT_WIDTH=2 with no ack → error on the 4th request cycle. An ack arriving on the 4th cycle instead completes normally. Same-cycle ack and err → error.
- `rst` asserted mid-BUS → next cycle `dbus_req_o`=0 and state IDLE; an ack arriving afterwards is ignored with no pulses.
